// File: rtl/btb_pkg.sv
// Shared BTB types and constants. The per-entry direction counter only exists
// when BTB_DIR_COUNTER_EN is defined; ADDR_WIDTH defaults to 32.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package btb_pkg;

  localparam int BTB_AW = `ADDR_WIDTH;

  typedef logic [1:0] btb_cnt_t;

  localparam btb_cnt_t CNT_WEAK_TAKEN = 2'b10;
  localparam btb_cnt_t CNT_MAX        = 2'b11;
  localparam btb_cnt_t CNT_MIN        = 2'b00;

  // Tag is stored zero-extended to the full address width so the struct
  // does not depend on the table depth; valid bits live in flops outside it.
  typedef struct packed {
    logic [BTB_AW-1:0] tag;
    logic [BTB_AW-1:0] target;
`ifdef BTB_DIR_COUNTER_EN
    btb_cnt_t          cnt;
`endif
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating up/down counter used for per-entry branch direction.
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic [1:0] cnt_cur,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt_cur;
    if (inc && (cnt_cur != CNT_MAX)) begin
      cnt_nxt = cnt_cur + 2'd1;
    end else if (dec && (cnt_cur != CNT_MIN)) begin
      cnt_nxt = cnt_cur - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a one-cycle registered lookup.
// Define BTB_DIR_COUNTER_EN to predict direction from a 2-bit counter per entry.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int AW      = `ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          query_valid,
  input  logic [AW-1:0] query_pc,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_pc,
  input  logic          upd_is_branch,
  input  logic          upd_taken,
  input  logic [AW-1:0] upd_target,
  output logic          pred_valid,
  output logic          pred_hit,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = AW - IW - 2;

  btb_entry_t         entry_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;

  btb_entry_t         rd_entry_q, rd_entry_d;
  logic               rd_valid_q, rd_valid_d;
  logic               pv_q, pv_d;
  logic [AW-1:0]      qpc_q, qpc_d;

  logic [IW-1:0]      q_idx, u_idx;
  logic [TW-1:0]      q_tag, u_tag;
  btb_entry_t         u_entry, wr_entry;
  logic               u_hit, wr_en;

  assign q_idx = query_pc[IW+1:2];
  assign u_idx = upd_pc[IW+1:2];
  assign u_tag = upd_pc[AW-1:IW+2];
  assign q_tag = qpc_q[AW-1:IW+2];

  // The update port looks at current state, so a same-cycle query sees pre-update contents.
  assign u_entry = entry_mem[u_idx];
  assign u_hit   = valid_q[u_idx] && (u_entry.tag == BTB_AW'(u_tag));

`ifdef BTB_DIR_COUNTER_EN
  logic [1:0] cnt_upd;

  btb_sat_counter u_cnt (
    .cnt_cur (u_entry.cnt),
    .inc     (upd_taken),
    .dec     (!upd_taken),
    .cnt_nxt (cnt_upd)
  );
`endif

  always_comb begin
    valid_d  = valid_q;
    wr_en    = 1'b0;
    wr_entry = u_entry;
    if (rst || flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        if (u_hit) begin
          wr_en = 1'b1;
          if (upd_taken) begin
            wr_entry.target = BTB_AW'(upd_target);
          end
`ifdef BTB_DIR_COUNTER_EN
          wr_entry.cnt = cnt_upd;
`endif
        end else if (upd_taken) begin
          wr_en            = 1'b1;
          valid_d[u_idx]   = 1'b1;
          wr_entry.tag     = BTB_AW'(u_tag);
          wr_entry.target  = BTB_AW'(upd_target);
`ifdef BTB_DIR_COUNTER_EN
          wr_entry.cnt     = CNT_WEAK_TAKEN;
`endif
        end
      end else if (u_hit) begin
        valid_d[u_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    pv_d       = query_valid;
    qpc_d      = query_pc;
    rd_entry_d = entry_mem[q_idx];
    rd_valid_d = valid_q[q_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      pv_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pv_q    <= pv_d;
    end
    qpc_q      <= qpc_d;
    rd_entry_q <= rd_entry_d;
    rd_valid_q <= rd_valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_mem[u_idx] <= wr_entry;
    end
  end

  always_comb begin
    pred_valid  = pv_q;
    pred_hit    = pv_q && rd_valid_q && (rd_entry_q.tag == BTB_AW'(q_tag));
`ifdef BTB_DIR_COUNTER_EN
    pred_taken  = pred_hit && rd_entry_q.cnt[1];
`else
    pred_taken  = pred_hit;
`endif
    pred_target = '0;
    if (pv_q) begin
      pred_target = pred_taken ? AW'(rd_entry_q.target) : (qpc_q + AW'(4));
    end
  end

  // Byte-offset bits and the counter LSB never influence a prediction.
  logic unused_bits;
`ifdef BTB_DIR_COUNTER_EN
  assign unused_bits = ^{upd_pc[1:0], rd_entry_q.cnt[0]};
`else
  assign unused_bits = ^upd_pc[1:0];
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed scoreboard bench for btb_predictor (ENTRIES=64, AW=32); expectations
// follow BTB_DIR_COUNTER_EN when it is defined for the build.
module tb_btb_predictor;

  localparam int AW = 32;
`ifdef BTB_DIR_COUNTER_EN
  localparam bit DIR = 1'b1;
`else
  localparam bit DIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, query_valid, upd_valid, upd_is_branch, upd_taken;
  logic [AW-1:0] query_pc, upd_pc, upd_target;
  logic          pred_valid, pred_hit, pred_taken;
  logic [AW-1:0] pred_target;

  btb_predictor #(.ENTRIES(64), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .query_valid   (query_valid),
    .query_pc      (query_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_is_branch (upd_is_branch),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .pred_valid    (pred_valid),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          hit;
    logic          taken;
    logic [AW-1:0] target;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;

  // ctr_tk is the hand-derived counter direction; without the counter a hit is always taken.
  function automatic void push_exp(input string n, input logic [AW-1:0] pc,
                                   input bit hit, input bit ctr_tk, input logic [AW-1:0] tgt);
    exp_t x;
    bit   tk;
    tk       = hit && (DIR ? ctr_tk : 1'b1);
    x.name   = n;
    x.hit    = hit;
    x.taken  = tk;
    x.target = tk ? tgt : pc + 32'd4;
    exp_q.push_back(x);
  endfunction

  task automatic drive(input bit qv, input logic [AW-1:0] qpc,
                       input bit uv, input logic [AW-1:0] upc, input bit ubr,
                       input bit utk, input logic [AW-1:0] utgt,
                       input bit fl, input bit r);
    query_valid   = qv;
    query_pc      = qpc;
    upd_valid     = uv;
    upd_pc        = upc;
    upd_is_branch = ubr;
    upd_taken     = utk;
    upd_target    = utgt;
    flush         = fl;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic query(input string n, input logic [AW-1:0] pc,
                       input bit hit, input bit ctr_tk, input logic [AW-1:0] tgt);
    push_exp(n, pc, hit, ctr_tk, tgt);
    drive(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [AW-1:0] pc, input bit br, input bit tk,
                        input logic [AW-1:0] tgt);
    drive(1'b0, '0, 1'b1, pc, br, tk, tgt, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pred_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pred: got pred_valid=1 hit=%0b taken=%0b target=%h, required no prediction",
                   pred_hit, pred_taken, pred_target);
        end else begin
          e = exp_q.pop_front();
          if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.target) begin
            errors++;
            $display("FAIL %s: got hit=%0b taken=%0b target=%h, required hit=%0b taken=%0b target=%h",
                     e.name, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
          end else begin
            $display("ok   %s: hit=%0b taken=%0b target=%h", e.name, pred_hit, pred_taken, pred_target);
          end
        end
      end else begin
        checks++;
        if (pred_valid !== 1'b0 || pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== '0) begin
          errors++;
          $display("FAIL idle_outputs: got valid=%b hit=%b taken=%b target=%h, required all zero",
                   pred_valid, pred_hit, pred_taken, pred_target);
        end
      end
      if (end_req && !end_done) begin
        end_done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_preds: got %0d predictions never delivered, required 0", exp_q.size());
        end
      end
    end
  end

  initial begin
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    mon_en = 1'b1;
    // Reset wins over a live query: nothing may appear.
    drive(1'b1, 32'h1c000000, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    query("cold_miss", 32'h1c000000, 1'b0, 1'b0, '0);

    update(32'h1c000010, 1'b1, 1'b1, 32'h1c000100);
    query("alloc_hit", 32'h1c000010, 1'b1, 1'b1, 32'h1c000100);
    update(32'h1c000010, 1'b1, 1'b0, 32'h0);
    query("weak_not_taken", 32'h1c000010, 1'b1, 1'b0, 32'h1c000100);
    query("alias_tag_miss", 32'h1c000110, 1'b0, 1'b0, '0);
    update(32'h1c000010, 1'b0, 1'b0, 32'h0);
    query("nonbranch_inval", 32'h1c000010, 1'b0, 1'b0, '0);

    // Same-cycle allocate and query: the lookup sees the empty entry.
    push_exp("same_cycle_old", 32'h1c000020, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h1c000020, 1'b1, 32'h1c000020, 1'b1, 1'b1, 32'h1c000200, 1'b0, 1'b0);
    query("same_cycle_new", 32'h1c000020, 1'b1, 1'b1, 32'h1c000200);

    // Counter walk: 2 -> 3 -> 3 -> 2 -> 1 -> 0 -> 0 -> 1 -> 2
    update(32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    update(32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    query("sat_high", 32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    update(32'h1c000020, 1'b1, 1'b0, 32'h0);
    query("sat_high_dec", 32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    update(32'h1c000020, 1'b1, 1'b0, 32'h0);
    query("cnt_one", 32'h1c000020, 1'b1, 1'b0, 32'h1c000200);
    update(32'h1c000020, 1'b1, 1'b0, 32'h0);
    update(32'h1c000020, 1'b1, 1'b0, 32'h0);
    query("sat_low_valid", 32'h1c000020, 1'b1, 1'b0, 32'h1c000200);
    update(32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    query("sat_low_inc", 32'h1c000020, 1'b1, 1'b0, 32'h1c000200);
    update(32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    query("cnt_two", 32'h1c000020, 1'b1, 1'b1, 32'h1c000200);

    // Flush drops the same-cycle allocation but the same-cycle query reads pre-flush state.
    push_exp("flush_preread", 32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    drive(1'b1, 32'h1c000020, 1'b1, 32'h1c000030, 1'b1, 1'b1, 32'h1c000300, 1'b1, 1'b0);
    query("post_flush_20", 32'h1c000020, 1'b0, 1'b0, '0);
    query("post_flush_30", 32'h1c000030, 1'b0, 1'b0, '0);
    query("post_flush_10", 32'h1c000010, 1'b0, 1'b0, '0);

    update(32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    query("pre_rst_hit", 32'h1c000020, 1'b1, 1'b1, 32'h1c000200);
    // Reset during a lookup: no prediction, and the table is empty afterwards.
    drive(1'b1, 32'h1c000020, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    query("post_rst_miss", 32'h1c000020, 1'b0, 1'b0, '0);

    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of table entries; power of two, 4..1024.
REQ-002 SHALL have parameter AW, default `ADDR_WIDTH, address width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, invalidate all entries.
REQ-006 SHALL have port query_valid, input, 1, fetch lookup request.
REQ-007 SHALL have port query_pc, input, AW, fetch PC to look up.
REQ-008 SHALL have port upd_valid, input, 1, resolved instruction report from execute.
REQ-009 SHALL have port upd_pc, input, AW, PC of the resolved instruction.
REQ-010 SHALL have port upd_is_branch, input, 1, resolved instruction is a branch.
REQ-011 SHALL have port upd_taken, input, 1, branch resolved taken.
REQ-012 SHALL have port upd_target, input, AW, resolved branch target.
REQ-013 SHALL have port pred_valid, output, 1, prediction result valid.
REQ-014 SHALL have port pred_hit, output, 1, lookup hit a valid entry with matching tag.
REQ-015 SHALL have port pred_taken, output, 1, predicted taken.
REQ-016 SHALL have port pred_target, output, AW, predicted next PC.

Function
REQ-017 SHALL be direct-mapped: IW = log2(ENTRIES); index = pc[IW+1:2]; tag = pc[AW-1:IW+2]; pc[1:0] ignored.
REQ-018 SHALL store per entry: valid bit, tag, AW-bit target, 2-bit saturating counter.
REQ-019 SHALL register the lookup with latency 1: pred_* in cycle N+1 reflect query_* sampled in cycle N; pred_valid = query_valid of cycle N.
REQ-020 SHALL drive pred_hit = entry valid AND tag equal.
REQ-021 SHALL drive pred_target = stored target when predicted taken, else query_pc+4 (modulo 2^AW).
REQ-022 SHALL, with pred_valid=0, drive pred_hit=0, pred_taken=0, pred_target=0.
REQ-023 SHALL, on upd_valid&upd_is_branch with a hit, increment the counter if taken (saturate at 3) or decrement it if not taken (saturate at 0), and overwrite the target when taken.
REQ-024 SHALL, on upd_valid&upd_is_branch&upd_taken with a miss, allocate: valid=1, new tag, target=upd_target, counter=2; a not-taken miss SHALL not allocate.
REQ-025 SHALL, on upd_valid&!upd_is_branch with a hit, clear that entry's valid bit.
REQ-026 SHALL, on a same-cycle query and update to the same index, read the pre-update state; there is no bypass.
REQ-027 SHALL give flush priority over update: flush clears every valid bit in one cycle and drops any same-cycle update; a same-cycle query still returns pred_valid=1 with a pre-flush lookup.

Reset
REQ-028 SHALL, while rst=1, clear all valid bits and drive pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0 from the next edge.
REQ-029 SHALL give rst priority over flush, update and query, and discard in-flight lookups.
REQ-030 SHALL leave tag, target and counter storage uninitialised under reset.

Configuration
REQ-031 SHALL, with BTB_DIR_COUNTER_EN defined, drive pred_taken = pred_hit AND counter[1].
REQ-032 SHALL, with BTB_DIR_COUNTER_EN undefined, drop the counter storage, drive pred_taken = pred_hit, and keep allocation and invalidation rules unchanged.

Structure
REQ-033 SHALL place the entry struct typedef, counter typedef and constants CNT_WEAK_TAKEN=2'b10 and CNT_MAX=2'b11 in package btb_pkg.
REQ-034 SHALL implement counter update in one sub-module, btb_sat_counter (2-bit, inc/dec with saturation).

Verification (ENTRIES=64, AW=32, macro defined unless noted)
REQ-035 SHALL check: reset, then query 0x1c000000 -> next cycle pred_valid=1, hit=0, taken=0, target=0x1c000004.
REQ-036 SHALL check: taken update pc=0x1c000010, target=0x1c000100, then query 0x1c000010 -> hit=1, taken=1, target=0x1c000100; one not-taken update to the same pc -> taken=0, target=0x1c000014; macro undefined -> taken=1.
REQ-037 SHALL check: after REQ-036 allocation, query 0x1c000110 (same index 4, different tag) -> hit=0; a non-branch update at 0x1c000010 -> later query of 0x1c000010 gives hit=0.
REQ-038 SHALL check: a same-cycle taken update and query at 0x1c000020 on an empty table -> that prediction hit=0; a repeat query -> hit=1.
REQ-039 SHALL check: counter at 3 plus a taken update stays 3; at 0 plus a not-taken update stays 0 and the entry stays valid.
REQ-040 SHALL check: flush with a same-cycle taken update -> all subsequent queries hit=0; assert rst mid-lookup -> pred_valid=0 on the next cycle.
